// File: rtl/wb_commit_pkg.sv
// Shared definitions for the write-back stage: datapath widths and the
// MemtoReg source-select encoding.
package wb_commit_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);
  localparam int CNT_W  = 64;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'b00,
    WB_SRC_MEM = 2'b01,
    WB_SRC_PC4 = 2'b10,
    WB_SRC_RSV = 2'b11
  } wb_src_e;

  typedef logic [XLEN-1:0]   xword_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/wb_commit_regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, and same-cycle write-through bypass on both reads.
module regfile_2r1w
  import wb_commit_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  xword_t    wdata_i,
  input  reg_addr_t raddr1_i,
  input  reg_addr_t raddr2_i,
  output xword_t    rdata1_o,
  output xword_t    rdata2_o
);

  xword_t regs_q [NREG];
  logic   wr_en;

  assign wr_en = we_i & (waddr_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Bypass lets ID see a value being written this very cycle.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (wr_en && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (wr_en && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Write-back stage: source select, register file ownership, registered
// commit trace and retired-instruction counter.
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic              clk_WB,
  input  logic              rst_n_WB,
  input  logic              en_WB,
  input  logic              valid_in_WB,
  input  logic [XLEN-1:0]   PC4_in_WB,
  input  logic [REG_AW-1:0] Rd_addr_in_WB,
  input  logic [XLEN-1:0]   ALU_in_WB,
  input  logic [XLEN-1:0]   DMem_data_in_WB,
  input  logic [1:0]        MemtoReg_in_WB,
  input  logic              RegWrite_in_WB,
  input  logic [XLEN-1:0]   pc_in_WB,
  input  logic [XLEN-1:0]   inst_in_WB,
  input  logic [REG_AW-1:0] rs1_addr_WB,
  input  logic [REG_AW-1:0] rs2_addr_WB,
  output logic [XLEN-1:0]   rs1_data_WB,
  output logic [XLEN-1:0]   rs2_data_WB,
  output logic [XLEN-1:0]   wb_data_WB,
  output logic              commit_valid_WB,
  output logic [XLEN-1:0]   commit_pc_WB,
  output logic [XLEN-1:0]   commit_inst_WB,
  output logic [REG_AW-1:0] commit_rd_WB,
  output logic [XLEN-1:0]   commit_wdata_WB,
  output logic [CNT_W-1:0]  instret_WB
);

  logic fire;
  logic we;

  logic              commit_valid_q, commit_valid_d;
  logic [XLEN-1:0]   commit_pc_q,    commit_pc_d;
  logic [XLEN-1:0]   commit_inst_q,  commit_inst_d;
  logic [REG_AW-1:0] commit_rd_q,    commit_rd_d;
  logic [XLEN-1:0]   commit_wdata_q, commit_wdata_d;
  logic [CNT_W-1:0]  instret_q,      instret_d;

  assign fire = en_WB & valid_in_WB;
  assign we   = fire & RegWrite_in_WB & (Rd_addr_in_WB != '0);

  // The reserved encoding yields zero so an unused select never leaks X.
  always_comb begin
    wb_data_WB = '0;
    unique case (wb_src_e'(MemtoReg_in_WB))
      WB_SRC_ALU: wb_data_WB = ALU_in_WB;
      WB_SRC_MEM: wb_data_WB = DMem_data_in_WB;
      WB_SRC_PC4: wb_data_WB = PC4_in_WB;
      WB_SRC_RSV: wb_data_WB = '0;
      default:    wb_data_WB = '0;
    endcase
  end

  regfile_2r1w u_regfile (
    .clk_i    (clk_WB),
    .rst_ni   (rst_n_WB),
    .we_i     (we),
    .waddr_i  (Rd_addr_in_WB),
    .wdata_i  (wb_data_WB),
    .raddr1_i (rs1_addr_WB),
    .raddr2_i (rs2_addr_WB),
    .rdata1_o (rs1_data_WB),
    .rdata2_o (rs2_data_WB)
  );

  // Trace fields hold while stalled; only the valid pulse drops.
  always_comb begin
    commit_valid_d = fire;
    commit_pc_d    = commit_pc_q;
    commit_inst_d  = commit_inst_q;
    commit_rd_d    = commit_rd_q;
    commit_wdata_d = commit_wdata_q;
    instret_d      = instret_q;
    if (fire) begin
      commit_pc_d    = pc_in_WB;
      commit_inst_d  = inst_in_WB;
      commit_rd_d    = we ? Rd_addr_in_WB : '0;
      commit_wdata_d = we ? wb_data_WB : '0;
      instret_d      = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_WB or negedge rst_n_WB) begin
    if (!rst_n_WB) begin
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_inst_q  <= '0;
      commit_rd_q    <= '0;
      commit_wdata_q <= '0;
      instret_q      <= '0;
    end else begin
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_inst_q  <= commit_inst_d;
      commit_rd_q    <= commit_rd_d;
      commit_wdata_q <= commit_wdata_d;
      instret_q      <= instret_d;
    end
  end

  assign commit_valid_WB = commit_valid_q;
  assign commit_pc_WB    = commit_pc_q;
  assign commit_inst_WB  = commit_inst_q;
  assign commit_rd_WB    = commit_rd_q;
  assign commit_wdata_WB = commit_wdata_q;
  assign instret_WB      = instret_q;

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit: writes, source select, x0,
// bypass, stalls, bubbles, non-writing commits and asynchronous reset.
module tb_wb_commit;

  logic        clk_WB = 1'b0;
  logic        rst_n_WB;
  logic        en_WB;
  logic        valid_in_WB;
  logic [31:0] PC4_in_WB;
  logic [4:0]  Rd_addr_in_WB;
  logic [31:0] ALU_in_WB;
  logic [31:0] DMem_data_in_WB;
  logic [1:0]  MemtoReg_in_WB;
  logic        RegWrite_in_WB;
  logic [31:0] pc_in_WB;
  logic [31:0] inst_in_WB;
  logic [4:0]  rs1_addr_WB;
  logic [4:0]  rs2_addr_WB;
  logic [31:0] rs1_data_WB;
  logic [31:0] rs2_data_WB;
  logic [31:0] wb_data_WB;
  logic        commit_valid_WB;
  logic [31:0] commit_pc_WB;
  logic [31:0] commit_inst_WB;
  logic [4:0]  commit_rd_WB;
  logic [31:0] commit_wdata_WB;
  logic [63:0] instret_WB;

  int assertCount = 0;
  int failCount   = 0;

  wb_commit dut (
    .clk_WB          (clk_WB),
    .rst_n_WB        (rst_n_WB),
    .en_WB           (en_WB),
    .valid_in_WB     (valid_in_WB),
    .PC4_in_WB       (PC4_in_WB),
    .Rd_addr_in_WB   (Rd_addr_in_WB),
    .ALU_in_WB       (ALU_in_WB),
    .DMem_data_in_WB (DMem_data_in_WB),
    .MemtoReg_in_WB  (MemtoReg_in_WB),
    .RegWrite_in_WB  (RegWrite_in_WB),
    .pc_in_WB        (pc_in_WB),
    .inst_in_WB      (inst_in_WB),
    .rs1_addr_WB     (rs1_addr_WB),
    .rs2_addr_WB     (rs2_addr_WB),
    .rs1_data_WB     (rs1_data_WB),
    .rs2_data_WB     (rs2_data_WB),
    .wb_data_WB      (wb_data_WB),
    .commit_valid_WB (commit_valid_WB),
    .commit_pc_WB    (commit_pc_WB),
    .commit_inst_WB  (commit_inst_WB),
    .commit_rd_WB    (commit_rd_WB),
    .commit_wdata_WB (commit_wdata_WB),
    .instret_WB      (instret_WB)
  );

  always #5 clk_WB = ~clk_WB;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic valid, input logic regWrite,
                               input logic [4:0] rd, input logic [1:0] memToReg,
                               input logic [31:0] alu, input logic [31:0] dmem,
                               input logic [31:0] pc4, input logic [31:0] pc,
                               input logic [31:0] inst);
    en_WB           = en;
    valid_in_WB     = valid;
    RegWrite_in_WB  = regWrite;
    Rd_addr_in_WB   = rd;
    MemtoReg_in_WB  = memToReg;
    ALU_in_WB       = alu;
    DMem_data_in_WB = dmem;
    PC4_in_WB       = pc4;
    pc_in_WB        = pc;
    inst_in_WB      = inst;
  endtask

  task automatic bubble();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk_WB);
    #1;
  endtask

  initial begin
    rst_n_WB    = 1'b0;
    rs1_addr_WB = 5'd5;
    rs2_addr_WB = 5'd6;
    bubble();
    #2;
    checkOutput("reset_commit_valid", 64'(commit_valid_WB), 64'd0);
    checkOutput("reset_instret", instret_WB, 64'd0);
    checkOutput("reset_rs1", 64'(rs1_data_WB), 64'd0);
    checkOutput("reset_commit_pc", 64'(commit_pc_WB), 64'd0);
    @(negedge clk_WB);
    rst_n_WB = 1'b1;

    // Basic ALU write to x5
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 32'h104,
                  32'h100, 32'h00000013);
    #1;
    checkOutput("basic_wb_data", 64'(wb_data_WB), 64'hDEADBEEF);
    tick();
    bubble();
    #1;
    checkOutput("basic_rs1", 64'(rs1_data_WB), 64'hDEADBEEF);
    checkOutput("basic_commit_valid", 64'(commit_valid_WB), 64'd1);
    checkOutput("basic_commit_rd", 64'(commit_rd_WB), 64'd5);
    checkOutput("basic_commit_wdata", 64'(commit_wdata_WB), 64'hDEADBEEF);
    checkOutput("basic_commit_pc", 64'(commit_pc_WB), 64'h100);
    checkOutput("basic_commit_inst", 64'(commit_inst_WB), 64'h00000013);
    checkOutput("basic_instret", instret_WB, 64'd1);
    tick();
    checkOutput("basic_pulse_once", 64'(commit_valid_WB), 64'd0);
    checkOutput("basic_trace_hold", 64'(commit_wdata_WB), 64'hDEADBEEF);

    // Source select: MEM to x6, PC4 to x8, reserved to x9
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd6, 2'b01, 32'h1111, 32'h1234, 32'h2222,
                  32'h104, 32'h0);
    #1;
    checkOutput("sel_mem_wb_data", 64'(wb_data_WB), 64'h1234);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd8, 2'b10, 32'h1111, 32'h3333, 32'h104,
                  32'h108, 32'h0);
    #1;
    checkOutput("sel_pc4_wb_data", 64'(wb_data_WB), 64'h104);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 2'b11, 32'h5555, 32'h6666, 32'h7777,
                  32'h10C, 32'h0);
    rs1_addr_WB = 5'd9;
    #1;
    checkOutput("sel_rsv_wb_data", 64'(wb_data_WB), 64'h0);
    checkOutput("sel_rsv_bypass", 64'(rs1_data_WB), 64'h0);
    checkOutput("sel_rsv_commit_wdata", 64'(commit_wdata_WB), 64'h104);
    tick();
    bubble();
    rs1_addr_WB = 5'd6;
    rs2_addr_WB = 5'd8;
    #1;
    checkOutput("sel_reg6", 64'(rs1_data_WB), 64'h1234);
    checkOutput("sel_reg8", 64'(rs2_data_WB), 64'h104);
    checkOutput("sel_rsv_commit_rd", 64'(commit_rd_WB), 64'd9);
    checkOutput("sel_rsv_commit_wdata0", 64'(commit_wdata_WB), 64'h0);
    checkOutput("sel_instret", instret_WB, 64'd4);
    rs1_addr_WB = 5'd9;
    #1;
    checkOutput("sel_reg9", 64'(rs1_data_WB), 64'h0);
    tick();

    // Write to x0 is discarded but still retires
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd0, 2'b00, 32'hFFFF, 32'h0, 32'h0,
                  32'h110, 32'h0);
    rs1_addr_WB = 5'd0;
    #1;
    checkOutput("x0_no_bypass", 64'(rs1_data_WB), 64'h0);
    tick();
    bubble();
    #1;
    checkOutput("x0_read", 64'(rs1_data_WB), 64'h0);
    checkOutput("x0_commit_valid", 64'(commit_valid_WB), 64'd1);
    checkOutput("x0_commit_rd", 64'(commit_rd_WB), 64'd0);
    checkOutput("x0_commit_wdata", 64'(commit_wdata_WB), 64'h0);
    checkOutput("x0_instret", instret_WB, 64'd5);
    tick();

    // Dual-port bypass with rs1 == rs2
    rs1_addr_WB = 5'd7;
    rs2_addr_WB = 5'd7;
    #1;
    checkOutput("bypass_before", 64'(rs1_data_WB), 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 2'b00, 32'hA5A5, 32'h0, 32'h0,
                  32'h114, 32'h0);
    #1;
    checkOutput("bypass_rs1", 64'(rs1_data_WB), 64'hA5A5);
    checkOutput("bypass_rs2", 64'(rs2_data_WB), 64'hA5A5);
    tick();

    // Stalled for three cycles with a would-be write to x10
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd10, 2'b00, 32'h77, 32'h0, 32'h0,
                  32'h118, 32'h0);
    rs1_addr_WB = 5'd10;
    #1;
    checkOutput("stall_no_bypass", 64'(rs1_data_WB), 64'h0);
    checkOutput("stall_prev_commit", 64'(commit_valid_WB), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_commit_valid", 64'(commit_valid_WB), 64'd0);
    end
    checkOutput("stall_rs1", 64'(rs1_data_WB), 64'h0);
    checkOutput("stall_instret", instret_WB, 64'd6);
    checkOutput("stall_pc_hold", 64'(commit_pc_WB), 64'h114);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd10, 2'b00, 32'h77, 32'h0, 32'h0,
                  32'h118, 32'h0);
    tick();
    checkOutput("bubble_rs1", 64'(rs1_data_WB), 64'h0);
    checkOutput("bubble_commit_valid", 64'(commit_valid_WB), 64'd0);
    checkOutput("bubble_instret", instret_WB, 64'd6);

    // Store commits without writing
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd2, 2'b00, 32'h1111, 32'h0, 32'h0,
                  32'h80, 32'h00A12023);
    rs1_addr_WB = 5'd2;
    rs2_addr_WB = 5'd5;
    #1;
    checkOutput("store_no_bypass", 64'(rs1_data_WB), 64'h0);
    tick();
    bubble();
    #1;
    checkOutput("store_commit_valid", 64'(commit_valid_WB), 64'd1);
    checkOutput("store_commit_pc", 64'(commit_pc_WB), 64'h80);
    checkOutput("store_commit_inst", 64'(commit_inst_WB), 64'h00A12023);
    checkOutput("store_commit_rd", 64'(commit_rd_WB), 64'd0);
    checkOutput("store_commit_wdata", 64'(commit_wdata_WB), 64'h0);
    checkOutput("store_instret", instret_WB, 64'd7);
    checkOutput("store_reg2", 64'(rs1_data_WB), 64'h0);
    checkOutput("store_reg5_intact", 64'(rs2_data_WB), 64'hDEADBEEF);

    // Asynchronous reset between clock edges
    rst_n_WB = 1'b0;
    #1;
    checkOutput("areset_rs2", 64'(rs2_data_WB), 64'h0);
    rs1_addr_WB = 5'd7;
    #1;
    checkOutput("areset_rs1", 64'(rs1_data_WB), 64'h0);
    checkOutput("areset_commit_valid", 64'(commit_valid_WB), 64'd0);
    checkOutput("areset_commit_pc", 64'(commit_pc_WB), 64'h0);
    checkOutput("areset_commit_inst", 64'(commit_inst_WB), 64'h0);
    checkOutput("areset_instret", instret_WB, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Write-back end of the MEM/WB pipeline register: consumes that register's outputs, selects write-back data, and owns the 32x32 architectural register file.
- Provides two read ports to ID with write-through bypass, a registered commit trace for the debug/trace monitor, and a 64-bit retired-instruction counter.
- Sits between the MEM/WB register and ID.

Parameters:
- XLEN, 32, datapath and register width.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- CNT_W, 64, width of the instret counter.

Ports:
- clk_WB  in  1  clock, rising edge.
- rst_n_WB  in  1  reset, asynchronous, active-low.
- en_WB  in  1  stage enable; low = stall, nothing commits.
- valid_in_WB  in  1  instruction in MEM/WB is real (not a bubble).
- PC4_in_WB  in  32  pc+4 for link write-back.
- Rd_addr_in_WB  in  5  destination register.
- ALU_in_WB  in  32  ALU result.
- DMem_data_in_WB  in  32  load data.
- MemtoReg_in_WB  in  2  write-back source select.
- RegWrite_in_WB  in  1  register write request.
- pc_in_WB  in  32  instruction pc.
- inst_in_WB  in  32  instruction word.
- rs1_addr_WB  in  5  ID read address 1.
- rs2_addr_WB  in  5  ID read address 2.
- rs1_data_WB  out  32  read data 1, combinational.
- rs2_data_WB  out  32  read data 2, combinational.
- wb_data_WB  out  32  selected write-back data, combinational, used for forwarding.
- commit_valid_WB  out  1  one-cycle pulse per retired instruction.
- commit_pc_WB  out  32  pc of the retired instruction.
- commit_inst_WB  out  32  instruction word of the retired instruction.
- commit_rd_WB  out  5  destination register; 0 when no write.
- commit_wdata_WB  out  32  written data; 0 when no write.
- instret_WB  out  64  count of retired instructions.

Behaviour:
- MemtoReg encoding: 00 = ALU_in_WB, 01 = DMem_data_in_WB, 10 = PC4_in_WB, 11 = 32'h0 (reserved, no X propagation).
- Commit condition: fire = en_WB & valid_in_WB.
- Write condition: we = fire & RegWrite_in_WB & (Rd_addr_in_WB != 0).
- Register file: on the rising edge with we, regs[Rd_addr_in_WB] <= wb_data_WB.
- regs[0] always reads 0; writes to it are discarded. No write when en_WB = 0 or valid_in_WB = 0.
- Read ports, combinational:
  - addr == 0 -> 0;
  - else if we and addr == Rd_addr_in_WB -> wb_data_WB (write-through bypass, same cycle);
  - else regs[addr].
- Both ports may bypass simultaneously; rs1 == rs2 is legal.
- Commit trace: registered, 1-cycle latency after the edge where fire = 1.
  - commit_valid_WB <= fire; it is deasserted the cycle after a stall or bubble, so there are no duplicate commits while stalled.
  - When fire: commit_pc/inst <= inputs; commit_rd <= we ? Rd : 0; commit_wdata <= we ? wb_data : 0.
  - When !fire: pc/inst/rd/wdata hold their previous values.
- instret_WB: increments by 1 on each edge with fire, regardless of RegWrite (stores and branches count). Wraps modulo 2^64 without a flag.
- Reset (rst_n_WB low, asynchronous, at any time including mid-stall):
  - all 32 registers = 0;
  - commit_valid = 0, commit_pc/inst/rd/wdata = 0;
  - instret = 0.
- Combinational outputs during reset follow the reset register contents.
- Inputs with valid_in_WB = 0 never affect state except through the combinational wb_data_WB.

Decomposition:
- Shared package (pipeline pkg): MemtoReg encoding constants (WB_SRC_ALU = 2'b00, WB_SRC_MEM = 2'b01, WB_SRC_PC4 = 2'b10), XLEN, and the register-address width.
- One natural sub-module: regfile_2r1w (async-reset 2-read/1-write array with x0 hardwiring and write-through bypass).
- The top level keeps the source mux, commit trace, and instret.

Test Plan:
- Reset then read: assert rst_n_WB = 0 mid-run after writes -> all rs reads = 0, commit_valid = 0, instret = 0 immediately (asynchronous).
- Basic write: valid = 1, en = 1, RegWrite = 1, Rd = 5, MemtoReg = 00, ALU = 32'hDEADBEEF -> next cycle rs1_addr = 5 reads DEADBEEF; commit_valid pulses once with rd = 5, wdata = DEADBEEF; instret = 1.
- Source select: MemtoReg = 01 with DMem = 32'h1234, then 10 with PC4 = 32'h104, then 11 -> regs get 1234, 104, 0; wb_data_WB matches combinationally in each case.
- x0 and bypass:
  - Rd = 0, ALU = 32'hFFFF -> rs reads of x0 = 0, commit_rd = 0, commit_wdata = 0, instret increments.
  - Rd = 7 write of 32'hA5A5 with rs1 = rs2 = 7 in the same cycle -> both read A5A5 before the edge.
- Stall/bubble: en_WB = 0 for 3 cycles with valid = 1, RegWrite = 1 -> no register change, commit_valid = 0, instret held. Then valid = 0, en = 1 -> still no write and no commit.
- Store/branch commit: valid = 1, RegWrite = 0, pc = 32'h80, inst = 32'h00A12023 -> commit_valid = 1, pc = 80, rd = 0; instret increments; register file unchanged.
